matrix_operand_streamer: RTL and testbench
==========================================

# matrix_operand_streamer

Sequential successor to the combinational column-major reorder. It accepts one row-major K×N operand matrix per valid/ready handshake and holds it in an internal buffer. It then streams the matrix out one vector per beat, as columns or as rows, selectable per matrix. Optional diagonal skew lets the beats feed a systolic-array edge directly.

## Interface
- K, 6: matrix rows.
- N, 6: matrix columns.
- DATA_WIDTH, 16: element width in bits.
- Derived, not overridable: L = max(K,N) output lanes; CW = $clog2(2*L) beat-counter width.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  matrix_flat, in_mode and in_skew are valid.
- in_ready  output  1  block can accept a matrix.
- in_mode  input  1  0 = column stream, 1 = row stream.
- in_skew  input  1  1 = diagonal skew enabled.
- matrix_flat  input  K*N*DATA_WIDTH  row-major; element (r,c) at bits [(r*N+c+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- out_valid  output  1  out_vec holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_vec  output  L*DATA_WIDTH  lane i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- out_last  output  1  current beat is the final beat of the matrix.

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - STREAM: in_ready=0, out_valid=1.
- Load: in_valid && in_ready at an edge does all of the following.
  - Captures matrix_flat, in_mode and in_skew into registers.
  - Clears the beat counter t to 0.
  - Moves to STREAM.
- Mode fixes vector count V and active lane count A.
  - Column mode: V=N, A=K; lane i = row i; vector j = column j.
  - Row mode: V=K, A=N; lane i = column i; vector j = row j.
- Beat count per matrix: B = V when skew=0; B = V+A-1 when skew=1.
- Beat t, lane i < A, vector index j:
  - j = t when skew=0; j = t−i when skew=1.
  - Column mode: lane = element (i,j). Row mode: lane = element (j,i).
  - Lane is 0 when j<0 or j≥V.
- Lanes i ≥ A are always 0.
- out_last = 1 iff state==STREAM and t==B−1.
- Beat handshake (out_valid && out_ready):
  - t<B−1: t increments.
  - t==B−1: state returns to IDLE.
- The captured buffer, mode and skew never change in STREAM; in_valid there is ignored.
- Outside STREAM: out_vec=0 and out_last=0.

## Timing
- Reset (async assert) takes effect immediately, without waiting for a clock edge:
  - state=IDLE, t=0, buffer cleared.
  - out_valid=0, out_last=0, out_vec=0.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after deassertion.
- Reset mid-stream abandons the matrix; no further beats are emitted.
- Load latency: handshake at edge e gives out_valid=1 with beat 0 in the cycle after e.
- Throughput: one beat per cycle while out_ready=1. There is a one-cycle IDLE bubble between matrices.
  - Minimum period per matrix is B+1 cycles.
- in_ready is registered state only; it has no combinational path from out_ready.
- Backpressure: while out_valid && !out_ready, out_vec, out_last and t hold stable.
- out_vec and out_last are combinational decodes of registered state (buffer, mode, skew, t); there are no input-to-output combinational paths.
- K=1 or N=1 is legal. With V=1 and skew=0, beat 0 has out_last=1.

## Structure
- Shared include file matrix_stream_defs.vh holds:
  - state encodings ST_IDLE and ST_STREAM;
  - mode encodings MODE_COL and MODE_ROW;
  - a max() macro for L.
- Sub-module matrix_element_select, purely combinational:
  - Inputs: buffer, mode, skew, t.
  - Output: out_vec.
  - Owns the index arithmetic and the zero-fill rules.
- The top level owns the FSM, the counter and the capture registers.

## Test plan
Configuration: K=2, N=3. Matrix [[1,2,3],[4,5,6]], so flat elements 0..5 = 1,2,3,4,5,6. out_vec is written (lane0,lane1,lane2).
- Column mode, no skew, out_ready=1 → beats (1,4,0),(2,5,0),(3,6,0); out_last on beat 3; in_ready returns the cycle after.
- Column mode, skew → 4 beats: (1,0,0),(2,4,0),(3,5,0),(0,6,0); out_last only on the 4th.
- Row mode, no skew → (1,2,3),(4,5,6). Row mode, skew → (1,0,0),(4,2,0),(0,5,3),(0,0,6).
- Backpressure: out_ready low 3 cycles during beat 1 of column skew → (2,4,0) and out_last=0 hold unchanged. in_valid pulsed during STREAM is ignored.
- Reset asserted during beat 2 → out_valid, out_vec and out_last drop to 0 immediately. After deassertion, a new row-mode load streams (1,2,3),(4,5,6) correctly.
- Back-to-back: in_valid held high with two different matrices → the second load is accepted exactly one cycle after the first matrix's last beat; no beat is lost or duplicated.

Source files
------------

// File: rtl/matrix_operand_streamer_pkg.sv
// Shared types and helpers for the matrix operand streamer: FSM state
// encodings, stream mode encodings and a max helper used to size the lanes.
package matrix_operand_streamer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  typedef enum logic {
    MODE_COL = 1'b0,
    MODE_ROW = 1'b1
  } mode_e;

  // Larger of two integers; gives the output lane count L = max(K,N).
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/matrix_operand_streamer_element_select.sv
// Combinational lane decoder: given the captured matrix, mode, skew and the
// beat counter, produces one output vector. All index arithmetic and the
// zero-fill rules (out-of-range vector index, inactive lanes) live here.
module matrix_operand_streamer_element_select
  import matrix_operand_streamer_pkg::*;
#(
  parameter int K          = 6,
  parameter int N          = 6,
  parameter int DATA_WIDTH = 16,
  parameter int L          = max_int(K, N),
  parameter int CW         = $clog2(2 * L)
) (
  input  logic [K*N*DATA_WIDTH-1:0] buffer,
  input  mode_e                     mode,
  input  logic                      skew,
  input  logic [CW-1:0]             t,
  output logic [L*DATA_WIDTH-1:0]   out_vec
);

  logic [L*DATA_WIDTH-1:0] vec_s;
  int                      vcount_s;
  int                      acount_s;

  // Vector count and active lane count follow from the stream mode.
  always_comb begin
    vcount_s = N;
    acount_s = K;
    case (mode)
      MODE_COL: begin
        vcount_s = N;
        acount_s = K;
      end
      MODE_ROW: begin
        vcount_s = K;
        acount_s = N;
      end
      default: begin
        vcount_s = N;
        acount_s = K;
      end
    endcase
  end

  // Per-lane element pick; lanes that fall off the skewed diagonal or past
  // the active lane count are zero-filled.
  always_comb begin
    int j_s;
    int elem_s;
    vec_s  = '0;
    j_s    = 0;
    elem_s = 0;
    for (int i = 0; i < L; i++) begin
      if (i < acount_s) begin
        if (skew) begin
          j_s = int'(t) - i;
        end else begin
          j_s = int'(t);
        end
        if ((j_s >= 0) && (j_s < vcount_s)) begin
          if (mode == MODE_ROW) begin
            elem_s = j_s * N + i;
          end else begin
            elem_s = i * N + j_s;
          end
          vec_s[i*DATA_WIDTH +: DATA_WIDTH] = buffer[elem_s*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          vec_s[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
      end else begin
        vec_s[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  assign out_vec = vec_s;

endmodule

// File: rtl/matrix_operand_streamer.sv
// Matrix operand streamer: captures one row-major KxN matrix per input
// handshake, then emits it one vector per beat as columns or rows, with
// optional diagonal skew for feeding a systolic-array edge.
module matrix_operand_streamer
  import matrix_operand_streamer_pkg::*;
#(
  parameter int K          = 6,
  parameter int N          = 6,
  parameter int DATA_WIDTH = 16,
  localparam int L         = max_int(K, N),
  localparam int CW        = $clog2(2 * L)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_mode,
  input  logic                      in_skew,
  input  logic [K*N*DATA_WIDTH-1:0] matrix_flat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [L*DATA_WIDTH-1:0]   out_vec,
  output logic                      out_last
);

  state_e                    state_r;
  state_e                    state_next_s;
  logic [CW-1:0]             t_r;
  logic [CW-1:0]             t_next_s;
  logic [K*N*DATA_WIDTH-1:0] buf_r;
  mode_e                     mode_r;
  logic                      skew_r;
  logic                      ready_r;
  logic                      valid_r;
  logic                      load_s;
  logic                      last_s;
  logic [CW-1:0]             last_idx_s;
  logic [L*DATA_WIDTH-1:0]   sel_vec_s;

  // Index of the final beat: V-1 unskewed, V+A-2 skewed.
  always_comb begin
    int v_s;
    int a_s;
    v_s = N;
    a_s = K;
    case (mode_r)
      MODE_COL: begin
        v_s = N;
        a_s = K;
      end
      MODE_ROW: begin
        v_s = K;
        a_s = N;
      end
      default: begin
        v_s = N;
        a_s = K;
      end
    endcase
    if (skew_r) begin
      last_idx_s = CW'(v_s + a_s - 2);
    end else begin
      last_idx_s = CW'(v_s - 1);
    end
  end

  assign last_s = valid_r && (t_r == last_idx_s);

  // Next-state and counter logic; a load is only accepted in IDLE once the
  // registered ready has come up after reset.
  always_comb begin
    state_next_s = state_r;
    t_next_s     = t_r;
    load_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && ready_r) begin
          state_next_s = ST_STREAM;
          t_next_s     = '0;
          load_s       = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (t_r == last_idx_s) begin
            state_next_s = ST_IDLE;
          end else begin
            t_next_s = t_r + CW'(1);
          end
        end else begin
          state_next_s = ST_STREAM;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        t_next_s     = '0;
      end
    endcase
  end

  // State, counter and registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      t_r     <= '0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      t_r     <= t_next_s;
      ready_r <= (state_next_s == ST_IDLE);
      valid_r <= (state_next_s == ST_STREAM);
    end
  end

  // Capture registers; frozen for the whole stream so in_valid is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r  <= '0;
      mode_r <= MODE_COL;
      skew_r <= 1'b0;
    end else if (load_s) begin
      buf_r  <= matrix_flat;
      mode_r <= mode_e'(in_mode);
      skew_r <= in_skew;
    end
  end

  matrix_operand_streamer_element_select #(
    .K          (K),
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .L          (L),
    .CW         (CW)
  ) u_select (
    .buffer  (buf_r),
    .mode    (mode_r),
    .skew    (skew_r),
    .t       (t_r),
    .out_vec (sel_vec_s)
  );

  assign in_ready  = ready_r;
  assign out_valid = valid_r;
  assign out_last  = last_s;
  assign out_vec   = valid_r ? sel_vec_s : '0;

endmodule

// File: tb/tb_matrix_operand_streamer.sv
// Directed bench for matrix_operand_streamer with K=2, N=3, 16-bit elements.
module tb_matrix_operand_streamer;

  localparam int K  = 2;
  localparam int N  = 3;
  localparam int DW = 16;
  localparam int L  = 3;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic              in_skew;
  logic [K*N*DW-1:0] matrix_flat;
  logic              out_valid;
  logic              out_ready;
  logic [L*DW-1:0]   out_vec;
  logic              out_last;

  int checks;
  int errors;

  logic [K*N*DW-1:0] mat_a;
  logic [K*N*DW-1:0] mat_b;

  matrix_operand_streamer #(
    .K          (K),
    .N          (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_skew     (in_skew),
    .matrix_flat (matrix_flat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_vec     (out_vec),
    .out_last    (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [L*DW-1:0] pack3(input int l0, input int l1, input int l2);
    return {DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one matrix for a single cycle; caller is in IDLE with in_ready=1.
  task automatic load(input logic mode, input logic skew, input logic [K*N*DW-1:0] mat);
    in_mode     = mode;
    in_skew     = skew;
    matrix_flat = mat;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_vec !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b last=%0b vec=%h ready=%0b, want 0 0 0 0",
               out_valid, out_last, out_vec, in_ready);
    end
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: in_ready=%0b want 0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_reset: in_ready=%0b valid=%0b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_col_noskew();
    logic [L*DW-1:0] exp_v [3];
    exp_v[0] = pack3(1, 4, 0);
    exp_v[1] = pack3(2, 5, 0);
    exp_v[2] = pack3(3, 6, 0);
    out_ready = 1'b1;
    load(1'b0, 1'b0, mat_a);
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_vec !== exp_v[b] || out_last !== ((b == 2) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL col_noskew beat %0d: valid=%0b vec=%h last=%0b, want 1 %h %0b",
                 b, out_valid, out_vec, out_last, exp_v[b], (b == 2));
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_vec !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL col_noskew_end: valid=%0b ready=%0b vec=%h last=%0b, want 0 1 0 0",
               out_valid, in_ready, out_vec, out_last);
    end
  endtask

  task automatic test_col_skew();
    logic [L*DW-1:0] exp_v [4];
    exp_v[0] = pack3(1, 0, 0);
    exp_v[1] = pack3(2, 4, 0);
    exp_v[2] = pack3(3, 5, 0);
    exp_v[3] = pack3(0, 6, 0);
    out_ready = 1'b1;
    load(1'b0, 1'b1, mat_a);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_vec !== exp_v[b] || out_last !== ((b == 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL col_skew beat %0d: valid=%0b vec=%h last=%0b, want 1 %h %0b",
                 b, out_valid, out_vec, out_last, exp_v[b], (b == 3));
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL col_skew_end: valid=%0b ready=%0b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_row();
    logic [L*DW-1:0] exp_n [2];
    logic [L*DW-1:0] exp_s [4];
    exp_n[0] = pack3(1, 2, 3);
    exp_n[1] = pack3(4, 5, 6);
    exp_s[0] = pack3(1, 0, 0);
    exp_s[1] = pack3(4, 2, 0);
    exp_s[2] = pack3(0, 5, 3);
    exp_s[3] = pack3(0, 0, 6);
    out_ready = 1'b1;
    load(1'b1, 1'b0, mat_a);
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_vec !== exp_n[b] || out_last !== ((b == 1) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL row_noskew beat %0d: valid=%0b vec=%h last=%0b, want 1 %h %0b",
                 b, out_valid, out_vec, out_last, exp_n[b], (b == 1));
      end
      step();
    end
    step();
    load(1'b1, 1'b1, mat_a);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_vec !== exp_s[b] || out_last !== ((b == 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL row_skew beat %0d: valid=%0b vec=%h last=%0b, want 1 %h %0b",
                 b, out_valid, out_vec, out_last, exp_s[b], (b == 3));
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL row_skew_end: valid=%0b ready=%0b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [L*DW-1:0] exp_v [4];
    exp_v[0] = pack3(1, 0, 0);
    exp_v[1] = pack3(2, 4, 0);
    exp_v[2] = pack3(3, 5, 0);
    exp_v[3] = pack3(0, 6, 0);
    out_ready = 1'b1;
    load(1'b0, 1'b1, mat_a);
    step();
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    in_mode     = 1'b1;
    in_skew     = 1'b0;
    matrix_flat = mat_b;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_vec !== exp_v[1] || out_last !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold %0d: valid=%0b vec=%h last=%0b ready=%0b, want 1 %h 0 0",
                 c, out_valid, out_vec, out_last, in_ready, exp_v[1]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_vec !== exp_v[b] || out_last !== ((b == 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL backpressure beat %0d: valid=%0b vec=%h last=%0b, want 1 %h %0b",
                 b, out_valid, out_vec, out_last, exp_v[b], (b == 3));
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_end: valid=%0b ready=%0b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    load(1'b0, 1'b1, mat_a);
    step();
    step();
    checks++;
    if (out_vec !== pack3(3, 5, 0)) begin
      errors++;
      $display("FAIL mid_reset_pre: vec=%h want %h", out_vec, pack3(3, 5, 0));
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_vec !== '0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: valid=%0b vec=%h last=%0b ready=%0b, want 0 0 0 0",
               out_valid, out_vec, out_last, in_ready);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_after: valid=%0b ready=%0b, want 0 1", out_valid, in_ready);
    end
    load(1'b1, 1'b0, mat_a);
    checks++;
    if (out_valid !== 1'b1 || out_vec !== pack3(1, 2, 3) || out_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_row0: valid=%0b vec=%h last=%0b, want 1 %h 0",
               out_valid, out_vec, out_last, pack3(1, 2, 3));
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_vec !== pack3(4, 5, 6) || out_last !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_row1: valid=%0b vec=%h last=%0b, want 1 %h 1",
               out_valid, out_vec, out_last, pack3(4, 5, 6));
    end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready   = 1'b1;
    in_mode     = 1'b1;
    in_skew     = 1'b0;
    matrix_flat = mat_a;
    in_valid    = 1'b1;
    step();
    checks++;
    if (out_vec !== pack3(1, 2, 3) || out_last !== 1'b0) begin
      errors++;
      $display("FAIL b2b_a0: vec=%h last=%0b want %h 0", out_vec, out_last, pack3(1, 2, 3));
    end
    step();
    matrix_flat = mat_b;
    #1;
    checks++;
    if (out_vec !== pack3(4, 5, 6) || out_last !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_a1: vec=%h last=%0b ready=%0b want %h 1 0",
               out_vec, out_last, in_ready, pack3(4, 5, 6));
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_bubble: valid=%0b ready=%0b want 0 1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_vec !== pack3(11, 12, 13) || out_last !== 1'b0) begin
      errors++;
      $display("FAIL b2b_b0: valid=%0b vec=%h last=%0b want 1 %h 0",
               out_valid, out_vec, out_last, pack3(11, 12, 13));
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_vec !== pack3(14, 15, 16) || out_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_b1: valid=%0b vec=%h last=%0b want 1 %h 1",
               out_valid, out_vec, out_last, pack3(14, 15, 16));
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: valid=%0b ready=%0b want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    mat_a       = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    mat_b       = {16'd16, 16'd15, 16'd14, 16'd13, 16'd12, 16'd11};
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_mode     = 1'b0;
    in_skew     = 1'b0;
    matrix_flat = '0;
    out_ready   = 1'b0;
    test_reset();
    test_col_noskew();
    test_col_skew();
    test_row();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
